prog_counter: RTL

Parametrised successor to the basic load/up-down counter. Adds:
- programmable terminal value (`limit`);
- variable step size;
- selectable wrap or saturate mode at the range boundary;
- a one-cycle terminal pulse and sticky overflow/underflow flags.

It is used wherever the design needs a modulo-N, strided or saturating event counter. It sits directly behind the block's control registers.

---
 rtl/prog_counter.sv | 189 ++++++++++++++++++
 1 files changed

// File: rtl/prog_counter.sv
// ---------------------------------------------------------------------------
// prog_counter
//
// Programmable event counter: modulo-N, strided or saturating. The count
// lives in the range 0..limit inclusive. Each enabled cycle it moves by
// `step` in the direction chosen by `up_down`. When it crosses the range
// boundary it either saturates or wraps, depending on `sat_mode`. Each
// crossing produces a one-cycle wrap_pulse and sets a sticky flag for its
// direction.
//
// Parameters
//   WIDTH   width of count_out, data_load and limit
//   STEP_W  width of step (assumed <= WIDTH)
//
// Ports
//   clk         clock; all state updates on the rising edge
//   rst         synchronous reset, active-high
//   load_n      active-low synchronous load of data_load (clamped to limit)
//   ce          count enable
//   up_down     1 = count up, 0 = count down
//   step        amount added/subtracted per enabled cycle
//   limit       terminal value; legal count range is 0..limit
//   sat_mode    1 = saturate at the boundary, 0 = wrap
//   clr_flags   clears ovf_sticky / unf_sticky (a same-edge event wins)
//   data_load   value to load
//   count_out   registered count
//   max_count   combinational, count_out == limit
//   zero        combinational, count_out == 0
//   wrap_pulse  registered, high for one cycle after a boundary event
//   ovf_sticky  sticky overflow flag
//   unf_sticky  sticky underflow flag
//
// Per-edge priority: rst > load_n=0 > ce=1 > hold.
// ---------------------------------------------------------------------------
module prog_counter #(
  parameter int WIDTH  = 8,
  parameter int STEP_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_n,
  input  logic              ce,
  input  logic              up_down,
  input  logic [STEP_W-1:0] step,
  input  logic [WIDTH-1:0]  limit,
  input  logic              sat_mode,
  input  logic              clr_flags,
  input  logic [WIDTH-1:0]  data_load,
  output logic [WIDTH-1:0]  count_out,
  output logic              max_count,
  output logic              zero,
  output logic              wrap_pulse,
  output logic              ovf_sticky,
  output logic              unf_sticky
);

  // The arithmetic uses two guard bits. One absorbs the carry of
  // count+step. The other is the sign bit of the down-wrap remainder.
  localparam int EW = WIDTH + 2;

  typedef enum logic [1:0] {
    EV_NONE = 2'd0,
    EV_OVF  = 2'd1,
    EV_UNF  = 2'd2
  } event_e;

  // State
  logic [WIDTH-1:0] r_count;
  logic             r_wrap;
  logic             r_ovf;
  logic             r_unf;

  // Zero-extended operands
  logic [EW-1:0]        w_cnt_x;
  logic [EW-1:0]        w_lim_x;
  logic [EW-1:0]        w_step_x;

  // Candidate results
  logic [EW-1:0]        w_sum;      // count + step, no truncation
  logic [EW-1:0]        w_up_wrap;  // sum - (limit + 1)
  logic signed [EW-1:0] w_dn_wrap;  // count + limit + 1 - step
  logic [WIDTH-1:0]     w_load_val;

  // Next-state decision for a counting (ce=1) edge
  logic [WIDTH-1:0]     w_next_count;
  event_e               w_event;
  logic                 w_count_en;
  logic                 w_ovf_set;
  logic                 w_unf_set;

  assign w_cnt_x  = EW'(r_count);
  assign w_lim_x  = EW'(limit);
  assign w_step_x = EW'(step);

  assign w_sum     = w_cnt_x + w_step_x;
  assign w_up_wrap = w_sum - w_lim_x - EW'(1);
  assign w_dn_wrap = $signed(w_cnt_x + w_lim_x + EW'(1) - w_step_x);

  // A load never escapes the legal range; out-of-range data is clamped.
  assign w_load_val = (data_load <= limit) ? data_load : limit;

  // Load takes precedence over counting. The flag-set and pulse paths
  // therefore only look at ce when load_n is inactive.
  assign w_count_en = load_n && ce;

  always_comb begin
    // NOTE: every signal assigned in this block gets a default first, so no
    // path can leave it unassigned and infer a latch.
    w_next_count = r_count;
    w_event      = EV_NONE;

    if (r_count > limit) begin
      // limit was lowered below the current count. Pull the count back into
      // range before anything else. This counts as an overflow in any mode
      // and direction.
      w_next_count = limit;
      w_event      = EV_OVF;
    end else if (w_step_x == '0) begin
      // A zero stride is a hold, not an event.
      w_next_count = r_count;
    end else if (up_down) begin
      if (w_sum <= w_lim_x) begin
        // Landing exactly on limit stays inside the range.
        w_next_count = w_sum[WIDTH-1:0];
      end else begin
        w_event = EV_OVF;
        if (sat_mode) begin
          w_next_count = limit;
        end else if (w_up_wrap <= w_lim_x) begin
          w_next_count = w_up_wrap[WIDTH-1:0];
        end else begin
          // The stride is larger than the whole range, so one wrap cannot
          // bring it back inside. Restart from zero.
          w_next_count = '0;
        end
      end
    end else begin
      if (w_step_x <= w_cnt_x) begin
        // step fits in WIDTH bits here because it is <= count.
        w_next_count = r_count - w_step_x[WIDTH-1:0];
      end else begin
        w_event = EV_UNF;
        if (sat_mode) begin
          w_next_count = '0;
        end else if (!w_dn_wrap[EW-1]) begin
          // A non-negative remainder is at most limit, because step > count.
          w_next_count = w_dn_wrap[WIDTH-1:0];
        end else begin
          w_next_count = limit;
        end
      end
    end
  end

  assign w_ovf_set = w_count_en && (w_event == EV_OVF);
  assign w_unf_set = w_count_en && (w_event == EV_UNF);

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the values from before the edge.
    if (rst) begin
      r_count <= '0;
      r_wrap  <= 1'b0;
      r_ovf   <= 1'b0;
      r_unf   <= 1'b0;
    end else begin
      if (!load_n) begin
        r_count <= w_load_val;
      end else if (ce) begin
        r_count <= w_next_count;
      end

      r_wrap <= w_ovf_set || w_unf_set;

      // A clear and a same-edge set on one flag: the set wins. The other
      // flag still clears.
      r_ovf  <= (r_ovf && !clr_flags) || w_ovf_set;
      r_unf  <= (r_unf && !clr_flags) || w_unf_set;
    end
  end

  assign count_out  = r_count;
  assign max_count  = (r_count == limit);
  assign zero       = (r_count == '0);
  assign wrap_pulse = r_wrap;
  assign ovf_sticky = r_ovf;
  assign unf_sticky = r_unf;

endmodule
